// File: rtl/stage_decode.sv
// ---------------------------------------------------------------------------
// stage_decode
//
// Decode/issue stage that feeds the SIMD execute stage. It takes 16-bit
// instructions from upstream and produces one registered control word per
// accepted instruction. It holds an instruction back while one of its source
// registers is still being written by an older vector instruction. A taken
// branch from execute squashes the word that is being issued.
//
// Optional feature macro: STAGE_DECODE_HAZARD_EN
//   defined   : a wbLatency-deep write scoreboard and the RAW hazard stall
//               are built in.
//   undefined : no scoreboard. The hazard term is tied to 0, and software
//               must leave wbLatency+1 slots between dependent instructions.
//
// Parameters
//   wbLatency  cycles a write spends past the execute input before the
//              register file shows it (1..7)
//   targetW    jump target width
//
// Ports
//   clk            clock; all state changes on the rising edge
//   reset          asynchronous, active-high reset
//   instr[15:0]    [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2,
//                  [8:0] jump target
//   instrValid     instr is valid
//   instrReady     decode takes instr this cycle (combinational)
//   stallIn        execute cannot take a new word; hold the outputs
//   flush          taken branch from execute; squash the word being issued
//   outValid       control word valid
//   ExecuteOp[2:0] ALU op for execute
//   pcWrEn[2:0]    100 unconditional, 010 jump-on-zero, 001 jump-on-negative
//   overwriteFlags update the NZ flags
//   regWrEn        result is written to rd
//   rd/rs1/rs2     vector register addresses
//   jumpTarget     instr[8:0]
//   illegal        one-cycle pulse after an unused opcode is accepted
//
// Handshake: a transfer happens on a rising edge where instrValid and
// instrReady are both 1. Upstream holds instr and instrValid stable until
// that edge. instrReady never depends on instrValid. An instruction that is
// accepted is never dropped, except by flush.
// ---------------------------------------------------------------------------
module stage_decode #(
    parameter int wbLatency = 3,
    parameter int targetW   = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [15:0]        instr,
    input  logic               instrValid,
    output logic               instrReady,
    input  logic               stallIn,
    input  logic               flush,
    output logic               outValid,
    output logic [2:0]         ExecuteOp,
    output logic [2:0]         pcWrEn,
    output logic               overwriteFlags,
    output logic               regWrEn,
    output logic [2:0]         rd,
    output logic [2:0]         rs1,
    output logic [2:0]         rs2,
    output logic [targetW-1:0] jumpTarget,
    output logic               illegal
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_VXOR = 4'h1,
        OP_VADD = 4'h2,
        OP_VSUB = 4'h3,
        OP_VMUL = 4'h4,
        OP_VSRL = 4'h5,
        OP_VSLL = 4'h6,
        OP_VCMP = 4'h7,
        OP_JMP  = 4'h8,
        OP_JZ   = 4'h9,
        OP_JN   = 4'hA
    } opcode_e;

    opcode_e opcode;
    logic [2:0] dec_op;
    logic [2:0] dec_pc;
    logic       dec_ovf;
    logic       dec_wr;
    logic       dec_ill;
    logic       hazard;
    logic       accept;

    assign opcode = opcode_e'(instr[15:12]);

    // Instruction decode
    always_comb begin
        dec_op  = 3'b000;
        dec_pc  = 3'b000;
        dec_ovf = 1'b0;
        dec_wr  = 1'b0;
        dec_ill = 1'b0;
        case (opcode)
            OP_NOP: ;
            OP_VXOR, OP_VADD, OP_VMUL, OP_VSRL, OP_VSLL: begin
                dec_op = instr[14:12];
                dec_wr = 1'b1;
            end
            OP_VSUB: begin
                dec_op  = instr[14:12];
                dec_wr  = 1'b1;
                dec_ovf = 1'b1;
            end
            // Compare uses the subtract datapath and keeps only the flags.
            OP_VCMP: begin
                dec_op  = 3'b011;
                dec_ovf = 1'b1;
            end
            OP_JMP: dec_pc = 3'b100;
            OP_JZ:  dec_pc = 3'b010;
            OP_JN:  dec_pc = 3'b001;
            default: dec_ill = 1'b1;
        endcase
    end

`ifdef STAGE_DECODE_HAZARD_EN
    // Scoreboard: slot 0 is the youngest write that has left the output
    // register. Slots advance only when execute takes a word.
    logic [wbLatency-1:0] sb_valid;
    logic [2:0]           sb_rd [wbLatency];
    logic                 reads_regs;
    logic [2:0]           src1;
    logic [2:0]           src2;

    assign reads_regs = (instr[15:12] >= 4'h1) && (instr[15:12] <= 4'h7);
    assign src1       = instr[8:6];
    assign src2       = instr[5:3];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb_valid <= '0;
            for (int i = 0; i < wbLatency; i++) begin
                sb_rd[i] <= 3'd0;
            end
        end else if (!stallIn) begin
            sb_valid[0] <= outValid & regWrEn;
            sb_rd[0]    <= rd;
            for (int i = 1; i < wbLatency; i++) begin
                sb_valid[i] <= sb_valid[i-1];
                sb_rd[i]    <= sb_rd[i-1];
            end
        end
    end

    // Only older writers count: the presented instruction's own rd is never
    // compared, so a destination that is also a source does not stall.
    always_comb begin
        hazard = 1'b0;
        if (reads_regs) begin
            if (outValid && regWrEn && (rd == src1 || rd == src2)) begin
                hazard = 1'b1;
            end
            for (int i = 0; i < wbLatency; i++) begin
                if (sb_valid[i] && (sb_rd[i] == src1 || sb_rd[i] == src2)) begin
                    hazard = 1'b1;
                end
            end
        end
    end
`else
    assign hazard = 1'b0;
`endif

    assign instrReady = !stallIn && !flush && !hazard;
    assign accept     = instrValid && instrReady;

    // Output register. Flush wins over stall so that a squashed word never
    // reaches execute. An illegal opcode is taken but issues as a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outValid       <= 1'b0;
            ExecuteOp      <= 3'b000;
            pcWrEn         <= 3'b000;
            overwriteFlags <= 1'b0;
            regWrEn        <= 1'b0;
            rd             <= 3'd0;
            rs1            <= 3'd0;
            rs2            <= 3'd0;
            jumpTarget     <= '0;
        end else if (flush || (!stallIn && !(accept && !dec_ill))) begin
            outValid       <= 1'b0;
            ExecuteOp      <= 3'b000;
            pcWrEn         <= 3'b000;
            overwriteFlags <= 1'b0;
            regWrEn        <= 1'b0;
            rd             <= 3'd0;
            rs1            <= 3'd0;
            rs2            <= 3'd0;
            jumpTarget     <= '0;
        end else if (!stallIn) begin
            outValid       <= 1'b1;
            ExecuteOp      <= dec_op;
            pcWrEn         <= dec_pc;
            overwriteFlags <= dec_ovf;
            regWrEn        <= dec_wr;
            rd             <= instr[11:9];
            rs1            <= instr[8:6];
            rs2            <= instr[5:3];
            jumpTarget     <= targetW'(instr[8:0]);
        end
    end

    // illegal is updated on every edge so that it stays high for one cycle
    // only, even when execute stalls the output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal <= 1'b0;
        end else begin
            illegal <= accept && dec_ill;
        end
    end

endmodule

// File: tb/tb_stage_decode.sv
module tb_stage_decode;

  localparam int WB = 3;
  localparam int TW = 9;
`ifdef STAGE_DECODE_HAZARD_EN
  localparam bit HZ = 1'b1;
  localparam int EXP_RAW_STALL = WB + 1;
`else
  localparam bit HZ = 1'b0;
  localparam int EXP_RAW_STALL = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  logic [15:0] instr;
  logic instr_valid_drv;
  logic stall_drv;
  logic flush_drv;

  logic          instrReady;
  logic          outValid;
  logic [2:0]    ExecuteOp;
  logic [2:0]    pcWrEn;
  logic          overwriteFlags;
  logic          regWrEn;
  logic [2:0]    rd;
  logic [2:0]    rs1;
  logic [2:0]    rs2;
  logic [TW-1:0] jumpTarget;
  logic          illegal;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  initial begin
    clk = 1'b0;
    #3;
    forever #5 clk = ~clk;
  end

  stage_decode #(.wbLatency(WB), .targetW(TW)) dut (
    .clk(clk),
    .reset(reset),
    .instr(instr),
    .instrValid(instr_valid_drv),
    .instrReady(instrReady),
    .stallIn(stall_drv),
    .flush(flush_drv),
    .outValid(outValid),
    .ExecuteOp(ExecuteOp),
    .pcWrEn(pcWrEn),
    .overwriteFlags(overwriteFlags),
    .regWrEn(regWrEn),
    .rd(rd),
    .rs1(rs1),
    .rs2(rs2),
    .jumpTarget(jumpTarget),
    .illegal(illegal)
  );

  // ---------------- behavioural model ----------------
  // Each register carries a countdown of accepted-cycle edges. The countdown
  // stays nonzero until a write that left the issue register becomes visible.
  logic          m_valid, m_ovf, m_wr, m_ill;
  logic [2:0]    m_op, m_pc, m_rd, m_rs1, m_rs2;
  logic [TW-1:0] m_jt;
  int            busy [8];

  logic [3:0] d_opc;
  logic       d_ill, d_alu, d_wr, d_ovf, d_reads;
  logic [2:0] d_op, d_pc;
  logic       m_hz, m_rdy, m_acc;

  always_comb begin
    d_opc   = instr[15:12];
    d_ill   = (d_opc > 4'hA);
    d_alu   = (d_opc >= 4'h1) && (d_opc <= 4'h6);
    d_wr    = d_alu;
    d_ovf   = (d_opc == 4'h3) || (d_opc == 4'h7);
    d_reads = (d_opc >= 4'h1) && (d_opc <= 4'h7);
    d_op    = d_alu ? d_opc[2:0] : ((d_opc == 4'h7) ? 3'd3 : 3'd0);
    d_pc    = (d_opc == 4'h8) ? 3'b100 : (d_opc == 4'h9) ? 3'b010 :
              (d_opc == 4'hA) ? 3'b001 : 3'b000;
  end

  always_comb begin
    m_hz = 1'b0;
    if (HZ && d_reads) begin
      for (int r = 0; r < 8; r++) begin
        if ((instr[8:6] == 3'(r)) || (instr[5:3] == 3'(r))) begin
          if (busy[r] > 0) m_hz = 1'b1;
          if (m_valid && m_wr && (m_rd == 3'(r))) m_hz = 1'b1;
        end
      end
    end
    m_rdy = !stall_drv && !flush_drv && !m_hz;
    m_acc = instr_valid_drv && m_rdy;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 0; m_op <= 0; m_pc <= 0; m_ovf <= 0; m_wr <= 0;
      m_rd <= 0; m_rs1 <= 0; m_rs2 <= 0; m_jt <= 0; m_ill <= 0;
      for (int r = 0; r < 8; r++) busy[r] <= 0;
    end else begin
      if (!stall_drv) begin
        for (int r = 0; r < 8; r++) busy[r] <= (busy[r] > 0) ? busy[r] - 1 : 0;
        if (HZ && m_valid && m_wr) busy[m_rd] <= WB;
      end
      if (flush_drv || (!stall_drv && !(m_acc && !d_ill))) begin
        m_valid <= 0; m_op <= 0; m_pc <= 0; m_ovf <= 0; m_wr <= 0;
        m_rd <= 0; m_rs1 <= 0; m_rs2 <= 0; m_jt <= 0;
      end else if (!stall_drv) begin
        m_valid <= 1; m_op <= d_op; m_pc <= d_pc; m_ovf <= d_ovf; m_wr <= d_wr;
        m_rd <= instr[11:9]; m_rs1 <= instr[8:6]; m_rs2 <= instr[5:3];
        m_jt <= instr[8:0];
      end
      m_ill <= m_acc && d_ill;
    end
  end

  // ---------------- scoreboard / compare ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      chk("cmp_outValid", 32'(outValid), 32'(m_valid));
      chk("cmp_ExecuteOp", 32'(ExecuteOp), 32'(m_op));
      chk("cmp_pcWrEn", 32'(pcWrEn), 32'(m_pc));
      chk("cmp_overwriteFlags", 32'(overwriteFlags), 32'(m_ovf));
      chk("cmp_regWrEn", 32'(regWrEn), 32'(m_wr));
      chk("cmp_rd", 32'(rd), 32'(m_rd));
      chk("cmp_rs1", 32'(rs1), 32'(m_rs1));
      chk("cmp_rs2", 32'(rs2), 32'(m_rs2));
      chk("cmp_jumpTarget", 32'(jumpTarget), 32'(m_jt));
      chk("cmp_illegal", 32'(illegal), 32'(m_ill));
      chk("cmp_instrReady", 32'(instrReady), 32'(m_rdy));
    end
  end

  // ---------------- driver tasks ----------------
  // Presents w until it is accepted; returns the number of refused cycles.
  task automatic send(input logic [15:0] w, output int stalls);
    int n;
    n = 0;
    instr = w;
    instr_valid_drv = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (instrReady) break;
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual no accept expected accept of %0h", w);
    end
    @(posedge clk);
    #1;
    stalls = n;
  endtask

  task automatic idle(input int n);
    instr_valid_drv = 1'b0;
    instr = 16'h0000;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  logic [15:0] b2b_tab [6] = '{16'h1BB8, 16'h4608, 16'h55B8, 16'h61F0, 16'h71B8, 16'h0000};

  initial begin
    int s;
    reset = 1'b1;
    instr = 16'h0000;
    instr_valid_drv = 1'b0;
    stall_drv = 1'b0;
    flush_drv = 1'b0;
    #2;
    chk("rst_outValid", 32'(outValid), 0);
    chk("rst_ExecuteOp", 32'(ExecuteOp), 0);
    chk("rst_pcWrEn", 32'(pcWrEn), 0);
    chk("rst_regWrEn", 32'(regWrEn), 0);
    chk("rst_illegal", 32'(illegal), 0);
    chk("rst_rd", 32'(rd), 0);
    #8;
    reset = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(instrReady), 1);
    @(posedge clk);
    #1;

    // VADD r1,r2,r3
    send(16'h2298, s);
    chk("vadd_stalls", 32'(s), 0);
    chk("vadd_outValid", 32'(outValid), 1);
    chk("vadd_op", 32'(ExecuteOp), 3'b010);
    chk("vadd_wr", 32'(regWrEn), 1);
    chk("vadd_rd", 32'(rd), 1);
    chk("vadd_rs1", 32'(rs1), 2);
    chk("vadd_rs2", 32'(rs2), 3);
    chk("vadd_ovf", 32'(overwriteFlags), 0);
    chk("vadd_pc", 32'(pcWrEn), 0);

    // VSUB r4,r1,r2 depends on r1
    send(16'h3850, s);
    chk("raw_stalls", 32'(s), 32'(EXP_RAW_STALL));
    chk("vsub_ovf", 32'(overwriteFlags), 1);
    chk("vsub_op", 32'(ExecuteOp), 3'b011);
    chk("vsub_rd", 32'(rd), 4);
    idle(6);

    // jumps
    send(16'h9055, s);
    chk("jz_stalls", 32'(s), 0);
    chk("jz_pc", 32'(pcWrEn), 3'b010);
    chk("jz_op", 32'(ExecuteOp), 0);
    chk("jz_wr", 32'(regWrEn), 0);
    chk("jz_target", 32'(jumpTarget), 32'h055);
    send(16'h8000, s);
    chk("jmp_pc", 32'(pcWrEn), 3'b100);
    send(16'hA000, s);
    chk("jn_pc", 32'(pcWrEn), 3'b001);
    idle(6);

    // back-to-back independent instructions
    foreach (b2b_tab[i]) begin
      send(b2b_tab[i], s);
      chk("b2b_stalls", 32'(s), 0);
      if (b2b_tab[i] == 16'h71B8) begin
        chk("vcmp_op", 32'(ExecuteOp), 3'b011);
        chk("vcmp_wr", 32'(regWrEn), 0);
        chk("vcmp_ovf", 32'(overwriteFlags), 1);
      end
    end
    idle(6);

    // rd equal to a source is not a self-hazard
    send(16'h2250, s);
    chk("self_src_stalls", 32'(s), 0);
    idle(6);

    // flush squashes the issuing slot
    instr = 16'h1BB8;
    instr_valid_drv = 1'b1;
    @(negedge clk);
    chk("flush_pre_ready", 32'(instrReady), 1);
    @(posedge clk); #1;
    chk("flush_pre_valid", 32'(outValid), 1);
    flush_drv = 1'b1;
    @(negedge clk);
    chk("flush_ready", 32'(instrReady), 0);
    @(posedge clk); #1;
    chk("flush_bubble", 32'(outValid), 0);
    flush_drv = 1'b0;
    @(negedge clk);
    chk("flush_post_ready", 32'(instrReady), 1);
    @(posedge clk); #1;
    chk("flush_reissue_valid", 32'(outValid), 1);
    chk("flush_reissue_rd", 32'(rd), 5);

    // stall freezes the outputs
    instr = 16'h4608;
    stall_drv = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_ready", 32'(instrReady), 0);
      chk("stall_hold_valid", 32'(outValid), 1);
      chk("stall_hold_rd", 32'(rd), 5);
      @(posedge clk); #1;
    end
    stall_drv = 1'b0;
    @(posedge clk); #1;
    chk("stall_release_rd", 32'(rd), 3);
    idle(6);

    // illegal opcode
    instr = 16'hF000;
    instr_valid_drv = 1'b1;
    @(negedge clk);
    chk("ill_ready", 32'(instrReady), 1);
    @(posedge clk); #1;
    chk("ill_pulse", 32'(illegal), 1);
    chk("ill_bubble", 32'(outValid), 0);
    instr = 16'h1BB8;
    @(negedge clk);
    chk("ill_next_ready", 32'(instrReady), 1);
    @(posedge clk); #1;
    chk("ill_pulse_end", 32'(illegal), 0);
    chk("ill_next_valid", 32'(outValid), 1);
    send(16'hB123, s);
    chk("ill_b_pulse", 32'(illegal), 1);
    idle(6);

    // reset in the middle of a hazard stall
    send(16'h2298, s);
    instr = 16'h3850;
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_outValid", 32'(outValid), 0);
    chk("midrst_regWrEn", 32'(regWrEn), 0);
    chk("midrst_rd", 32'(rd), 0);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 32'(instrReady), 1);
    @(posedge clk); #1;
    chk("midrst_issue_rd", 32'(rd), 4);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
